// File: rtl/probe_trace_buffer.sv
// ---------------------------------------------------------------------------
// probe_trace_buffer
//   Multi-channel capture buffer for on-chip probe and trace data. Each of the
//   CHANNELS channels owns an independent DEPTH-entry FIFO of DATA_W-bit
//   entries. A full channel either drops its oldest entry (OVERWRITE=1) or
//   drops the incoming write (OVERWRITE=0); in both cases the sticky
//   overflow flag of that channel is set. One shared, show-ahead read port
//   presents the oldest entry of the channel chosen by read_select_i.
//
//   Read handshake: read_valid_o is high when the selected channel holds at
//   least one entry; read_data_o is then its oldest entry. An entry is
//   consumed (popped) at a rising clock edge where read_valid_o and
//   read_ready_i are both high. read_ready_i without read_valid_o has no
//   effect, and read_valid_o does not depend on read_ready_i.
//
// Ports
//   clock_i        clock, rising edge
//   reset_i        synchronous active-high reset
//   wen_i          per-channel write enable
//   write_i        packed write data, channel c = write_i[c*DATA_W +: DATA_W]
//   clear_i        synchronous flush of all channels (beats wen and pop)
//   read_select_i  channel shown on the read port
//   read_ready_i   consumer accepts read_data_o this cycle
//   read_valid_o   selected channel is non-empty
//   read_data_o    oldest entry of the selected channel, 0 when not valid
//   read_count_o   occupancy of the selected channel, 0..DEPTH
//   overflow_o     sticky per-channel "an entry was lost" flag
// ---------------------------------------------------------------------------
module probe_trace_buffer #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int OVERWRITE = 1,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [CHANNELS-1:0]          wen_i,
    input  logic [CHANNELS*DATA_W-1:0]   write_i,
    input  logic                         clear_i,
    input  logic [SEL_W-1:0]             read_select_i,
    input  logic                         read_ready_i,
    output logic                         read_valid_o,
    output logic [DATA_W-1:0]            read_data_o,
    output logic [CNT_W-1:0]             read_count_o,
    output logic [CHANNELS-1:0]          overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage is deliberately not reset; occupancy alone decides validity.
    logic [DATA_W-1:0] mem_q [CHANNELS][DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0]  wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0]  rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0]  rd_ptr_d [CHANNELS];
    logic [CNT_W-1:0]  count_q  [CHANNELS];
    logic [CNT_W-1:0]  count_d  [CHANNELS];
    logic [CHANNELS-1:0] overflow_q;
    logic [CHANNELS-1:0] overflow_d;

    logic [CHANNELS-1:0] sel_hit;   // one-hot decode of read_select_i
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] store;     // entry written into memory this cycle

    // Select decode. An out-of-range select matches no channel, so the read
    // port shows zeros and no pop can happen.
    always_comb begin
        sel_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sel_hit[c] = (read_select_i == SEL_W'(c));
        end
    end

    // Read port: purely combinational from registered state and the select.
    always_comb begin
        read_valid_o = 1'b0;
        read_data_o  = '0;
        read_count_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_hit[c]) begin
                read_count_o = count_q[c];
                if (count_q[c] != '0) begin
                    read_valid_o = 1'b1;
                    read_data_o  = mem_q[c][rd_ptr_q[c]];
                end
            end
        end
    end

    // Per-channel next state.
    always_comb begin
        store      = '0;
        pop        = '0;
        full       = '0;
        overflow_d = overflow_q;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];

            pop[c]  = sel_hit[c] && read_ready_i && (count_q[c] != '0);
            full[c] = (count_q[c] == CNT_W'(DEPTH));

            if (clear_i) begin
                wr_ptr_d[c]   = '0;
                rd_ptr_d[c]   = '0;
                count_d[c]    = '0;
                overflow_d[c] = 1'b0;
            end else begin
                if (pop[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
                end
                if (wen_i[c]) begin
                    if (!full[c] || pop[c]) begin
                        // Room available, or a same-cycle pop frees a slot.
                        store[c]    = 1'b1;
                        wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
                        if (!pop[c]) begin
                            count_d[c] = count_q[c] + CNT_W'(1);
                        end
                    end else if (OVERWRITE != 0) begin
                        // Full: the new entry replaces the oldest one.
                        store[c]      = 1'b1;
                        wr_ptr_d[c]   = wr_ptr_q[c] + PTR_W'(1);
                        rd_ptr_d[c]   = rd_ptr_q[c] + PTR_W'(1);
                        overflow_d[c] = 1'b1;
                    end else begin
                        // Full: the new entry is discarded.
                        overflow_d[c] = 1'b1;
                    end
                end else if (pop[c]) begin
                    count_d[c] = count_q[c] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            overflow_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            overflow_q <= overflow_d;
        end
    end

    // Memory write port. A write that lands during reset is harmless because
    // the pointers and counts come out of reset at zero.
    always_ff @(posedge clock_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (store[c]) begin
                mem_q[c][wr_ptr_q[c]] <= write_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_probe_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_probe_trace_buffer
//   Directed bench for probe_trace_buffer. dut_a: 4 channels, overwrite on
//   full. dut_b: 5 channels (3-bit select), drop on full, used for the drop
//   policy and out-of-range select.
// ---------------------------------------------------------------------------
module tb_probe_trace_buffer;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    logic clear;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- dut_a signals ----------------
    logic [3:0]   wen_a;
    logic [255:0] write_a;
    logic [1:0]   sel_a;
    logic         ready_a;
    logic         valid_a;
    logic [63:0]  data_a;
    logic [4:0]   count_a;
    logic [3:0]   ovf_a;

    // ---------------- dut_b signals ----------------
    logic [4:0]   wen_b;
    logic [319:0] write_b;
    logic [2:0]   sel_b;
    logic         ready_b;
    logic         valid_b;
    logic [63:0]  data_b;
    logic [4:0]   count_b;
    logic [4:0]   ovf_b;

    probe_trace_buffer #(
        .DATA_W(64), .DEPTH(16), .CHANNELS(4), .OVERWRITE(1)
    ) dut_a (
        .clock_i       (clock),
        .reset_i       (reset),
        .wen_i         (wen_a),
        .write_i       (write_a),
        .clear_i       (clear),
        .read_select_i (sel_a),
        .read_ready_i  (ready_a),
        .read_valid_o  (valid_a),
        .read_data_o   (data_a),
        .read_count_o  (count_a),
        .overflow_o    (ovf_a)
    );

    probe_trace_buffer #(
        .DATA_W(64), .DEPTH(16), .CHANNELS(5), .OVERWRITE(0)
    ) dut_b (
        .clock_i       (clock),
        .reset_i       (reset),
        .wen_i         (wen_b),
        .write_i       (write_b),
        .clear_i       (clear),
        .read_select_i (sel_b),
        .read_ready_i  (ready_b),
        .read_valid_o  (valid_b),
        .read_data_o   (data_b),
        .read_count_o  (count_b),
        .overflow_o    (ovf_b)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic write_a_ch(input int ch, input logic [63:0] d);
        wen_a = '0;
        wen_a[ch] = 1'b1;
        write_a[ch*64 +: 64] = d;
        step();
        wen_a = '0;
    endtask

    task automatic write_b_ch(input int ch, input logic [63:0] d);
        wen_b = '0;
        wen_b[ch] = 1'b1;
        write_b[ch*64 +: 64] = d;
        step();
        wen_b = '0;
    endtask

    // Pop every queued expectation from one dut_a channel and compare.
    task automatic drain_a(input int ch, input string tag);
        int n;
        n = exp_q.size();
        sel_a   = 2'(ch);
        ready_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            settle();
            check_eq({tag, "_valid"}, 64'(valid_a), 64'd1);
            check_eq({tag, "_data"}, data_a, exp_q.pop_front());
            step();
        end
        ready_a = 1'b0;
        settle();
        check_eq({tag, "_empty"}, 64'(valid_a), 64'd0);
    endtask

    task automatic drain_b(input int ch, input string tag);
        int n;
        n = exp_q.size();
        sel_b   = 3'(ch);
        ready_b = 1'b1;
        for (int i = 0; i < n; i++) begin
            settle();
            check_eq({tag, "_valid"}, 64'(valid_b), 64'd1);
            check_eq({tag, "_data"}, data_b, exp_q.pop_front());
            step();
        end
        ready_b = 1'b0;
        settle();
        check_eq({tag, "_empty"}, 64'(valid_b), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; clear = 1'b0;
        wen_a = '0; write_a = '0; sel_a = '0; ready_a = 1'b0;
        wen_b = '0; write_b = '0; sel_b = '0; ready_b = 1'b0;
        step();
        step();
        reset = 1'b0;
        settle();

        // Reset state.
        check_eq("rst_valid", 64'(valid_a), 64'd0);
        check_eq("rst_data",  data_a, 64'd0);
        check_eq("rst_count", 64'(count_a), 64'd0);
        check_eq("rst_ovf_a", 64'(ovf_a), 64'd0);
        check_eq("rst_ovf_b", 64'(ovf_b), 64'd0);

        // 1: fill ch0 with 1..16, drain in order.
        for (int i = 1; i <= 16; i++) begin
            write_a_ch(0, 64'(i));
            exp_q.push_back(64'(i));
        end
        sel_a = 2'd0;
        settle();
        check_eq("fill_count", 64'(count_a), 64'd16);
        drain_a(0, "fill");
        check_eq("fill_count_end", 64'(count_a), 64'd0);
        check_eq("fill_ovf", 64'(ovf_a), 64'd0);

        // 2: overwrite policy on ch1, 1..20 leaves 5..20.
        for (int i = 1; i <= 20; i++) begin
            write_a_ch(1, 64'(i));
            exp_q.push_back(64'(i));
            if (exp_q.size() > 16) void'(exp_q.pop_front());
        end
        sel_a = 2'd1;
        settle();
        check_eq("ovw_count", 64'(count_a), 64'd16);
        check_eq("ovw_first", data_a, 64'd5);
        check_eq("ovw_ovf1", 64'(ovf_a), 64'b0010);
        drain_a(1, "ovw");

        // 3: drop policy on dut_b ch2, 1..20 keeps 1..16.
        for (int i = 1; i <= 20; i++) begin
            write_b_ch(2, 64'(i));
            if (exp_q.size() < 16) exp_q.push_back(64'(i));
        end
        sel_b = 3'd2;
        settle();
        check_eq("drop_count", 64'(count_b), 64'd16);
        check_eq("drop_ovf2", 64'(ovf_b), 64'b00100);
        drain_b(2, "drop");

        // 4: ch3 full, write 17 with a pop in the same cycle.
        for (int i = 1; i <= 16; i++) begin
            write_a_ch(3, 64'(i));
            exp_q.push_back(64'(i));
        end
        sel_a   = 2'd3;
        ready_a = 1'b1;
        wen_a   = 4'b1000;
        write_a[3*64 +: 64] = 64'd17;
        settle();
        check_eq("fullwp_pop", data_a, 64'd1);
        step();
        void'(exp_q.pop_front());
        exp_q.push_back(64'd17);
        wen_a   = '0;
        ready_a = 1'b0;
        settle();
        check_eq("fullwp_count", 64'(count_a), 64'd16);
        check_eq("fullwp_ovf3", 64'(ovf_a[3]), 64'd0);
        check_eq("fullwp_tail", exp_q[15], 64'd17);
        drain_a(3, "fullwp");

        // 5: all four channels written in the same cycles, data = ch*16+k+1.
        for (int k = 0; k < 4; k++) begin
            wen_a = 4'hf;
            for (int c = 0; c < 4; c++) write_a[c*64 +: 64] = 64'(c*16 + k + 1);
            step();
        end
        wen_a = '0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                sel_a   = 2'(c);
                ready_a = 1'b1;
                settle();
                check_eq("iso_count", 64'(count_a), 64'(4 - k));
                check_eq("iso_data", data_a, 64'(c*16 + k + 1));
                step();
            end
        end
        ready_a = 1'b0;

        // Out-of-range select on dut_b (5 channels, select 5).
        for (int c = 0; c < 5; c++) write_b_ch(c, 64'(100 + c));
        sel_b   = 3'd5;
        ready_b = 1'b1;
        settle();
        check_eq("oor_valid", 64'(valid_b), 64'd0);
        check_eq("oor_data",  data_b, 64'd0);
        check_eq("oor_count", 64'(count_b), 64'd0);
        step();
        ready_b = 1'b0;
        sel_b   = 3'd0;
        settle();
        check_eq("oor_nopop", 64'(count_b), 64'd1);
        sel_b = 3'd4;
        settle();
        check_eq("ch4_data", data_b, 64'd104);

        // 6: clear with a write on ch0 and a pending pop in the same cycle.
        write_a_ch(0, 64'hA1);
        write_a_ch(0, 64'hA2);
        check_eq("clr_pre_ovf", 64'(ovf_a), 64'b0010);
        sel_a   = 2'd0;
        ready_a = 1'b1;
        clear   = 1'b1;
        wen_a   = 4'b0001;
        write_a[63:0] = 64'hA3;
        step();
        clear   = 1'b0;
        wen_a   = '0;
        ready_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sel_a = 2'(c);
            settle();
            check_eq("clr_count", 64'(count_a), 64'd0);
            check_eq("clr_valid", 64'(valid_a), 64'd0);
            check_eq("clr_data",  data_a, 64'd0);
        end
        check_eq("clr_ovf_a", 64'(ovf_a), 64'd0);
        check_eq("clr_ovf_b", 64'(ovf_b), 64'd0);
        sel_b = 3'd4;
        settle();
        check_eq("clr_count_b", 64'(count_b), 64'd0);

        // Writes resume normally after clear.
        write_a_ch(0, 64'h55);
        sel_a = 2'd0;
        settle();
        check_eq("post_clr_data", data_a, 64'h55);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
